// File: rtl/imem_pkg.sv
// imem_pkg: shared types and helpers for the multi-port instruction memory.
//   imem_state_e    - controller states (sweep clear, idle, burst load)
//   WORD_ALIGN_BITS - byte-offset bits below the word index
//   word_index()    - byte address -> word index, masked to addrw bits
package imem_pkg;

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StLoad
    } imem_state_e;

    localparam int unsigned WORD_ALIGN_BITS = 2;
    localparam int unsigned MAX_ADDR_BITS   = 64;

    // Upper address bits beyond the array depth are dropped, so any byte address aliases
    // onto (addr >> 2) mod depth.
    function automatic logic [MAX_ADDR_BITS-1:0] word_index(
        input logic [MAX_ADDR_BITS-1:0] addr,
        input int unsigned              addrw
    );
        logic [MAX_ADDR_BITS-1:0] mask;
        mask = (MAX_ADDR_BITS'(1) << addrw) - MAX_ADDR_BITS'(1);
        return (addr >> WORD_ALIGN_BITS) & mask;
    endfunction

endpackage

// File: rtl/imem_mp_if.sv
// imem_mp_if: bundle of the read ports and the burst-load port of imem_mp.
//   rd_*  - NREAD valid/ready read ports, registered data/strobe/misalign responses
//   ld_*  - streaming burst loader (start/base/len, beat valid/ready/data, done pulse)
//   busy  - memory is clearing or loading
// Modports: slave = the memory, master = the host/fetch side.
interface imem_mp_if #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ADDRW    = 8
);
    logic [NREAD-1:0]          rd_valid;
    logic [NREAD*BITWIDTH-1:0] rd_addr;
    logic [NREAD-1:0]          rd_ready;
    logic [NREAD*BITWIDTH-1:0] rd_data;
    logic [NREAD-1:0]          rd_data_valid;
    logic [NREAD-1:0]          rd_misalign;
    logic                      ld_start;
    logic [BITWIDTH-1:0]       ld_base;
    logic [ADDRW:0]            ld_len;
    logic [BITWIDTH-1:0]       ld_data;
    logic                      ld_valid;
    logic                      ld_ready;
    logic                      ld_done;
    logic                      busy;

    modport slave (
        input  rd_valid, rd_addr, ld_start, ld_base, ld_len, ld_data, ld_valid,
        output rd_ready, rd_data, rd_data_valid, rd_misalign, ld_ready, ld_done, busy
    );

    modport master (
        output rd_valid, rd_addr, ld_start, ld_base, ld_len, ld_data, ld_valid,
        input  rd_ready, rd_data, rd_data_valid, rd_misalign, ld_ready, ld_done, busy
    );
endinterface

// File: rtl/imem_read_port.sv
// imem_read_port: response register for one read port.
//   clock, reset - clock, synchronous active-low reset
//   accept       - request handshake completed this cycle
//   addr_lo      - byte-offset bits of the request address
//   mem_word     - array word selected by the request index
//   data         - registered read data, held until the next accept
//   data_valid   - one-cycle strobe following each accept
//   misalign     - request had a non-zero byte offset, held with data
module imem_read_port
    import imem_pkg::*;
#(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       accept,
    input  logic [WORD_ALIGN_BITS-1:0] addr_lo,
    input  logic [BITWIDTH-1:0]        mem_word,
    output logic [BITWIDTH-1:0]        data,
    output logic                       data_valid,
    output logic                       misalign
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            data_valid <= accept;
            if (accept) begin
                data     <= mem_word;
                misalign <= |addr_lo;
            end
        end
    end

endmodule

// File: rtl/imem_mp.sv
// imem_mp: instruction memory with NREAD registered read ports and a burst loader.
//   clock, reset - clock, synchronous active-low reset
//   bus          - imem_mp_if slave: read ports, burst-load port, busy
// After reset the array is swept to zero one word per cycle; reads are only accepted in
// idle, so neither the sweep nor a burst can collide with a read.
module imem_mp
    import imem_pkg::*;
#(
    parameter int unsigned  ADDRSIZE = 256,
    parameter int unsigned  BITWIDTH = 32,
    parameter int unsigned  NREAD    = 2,
    localparam int unsigned ADDRW    = $clog2(ADDRSIZE)
) (
    input logic       clock,
    input logic       reset,
    imem_mp_if.slave  bus
);

    localparam logic [ADDRW:0]   DepthLen = (ADDRW+1)'(ADDRSIZE);
    localparam logic [ADDRW-1:0] LastIdx  = ADDRW'(ADDRSIZE - 1);

    function automatic logic [ADDRW-1:0] to_index(input logic [BITWIDTH-1:0] addr);
        return ADDRW'(word_index(MAX_ADDR_BITS'(addr), ADDRW));
    endfunction

    logic [BITWIDTH-1:0] mem [ADDRSIZE];

    imem_state_e       state_q, state_d;
    logic [ADDRW-1:0]  clr_ptr_q, clr_ptr_d;
    logic [ADDRW-1:0]  ld_ptr_q, ld_ptr_d;
    logic [ADDRW:0]    ld_rem_q, ld_rem_d;
    logic              ld_done_q, ld_done_d;

    logic              mem_we;
    logic [ADDRW-1:0]  mem_waddr;
    logic [BITWIDTH-1:0] mem_wdata;
    logic              rd_en;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        ld_rem_d  = ld_rem_q;
        ld_done_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + ADDRW'(1);
                if (clr_ptr_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (bus.ld_start) begin
                    if (bus.ld_len == '0) begin
                        ld_done_d = 1'b1;
                    end else begin
                        state_d  = StLoad;
                        ld_ptr_d = to_index(bus.ld_base);
                        // Longer bursts would only overwrite their own earlier beats.
                        ld_rem_d = (bus.ld_len > DepthLen) ? DepthLen : bus.ld_len;
                    end
                end
            end
            StLoad: begin
                if (bus.ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_ptr_q;
                    mem_wdata = bus.ld_data;
                    ld_ptr_d  = ld_ptr_q + ADDRW'(1);
                    ld_rem_d  = ld_rem_q - (ADDRW+1)'(1);
                    if (ld_rem_q == (ADDRW+1)'(1)) begin
                        state_d   = StIdle;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            ld_ptr_q  <= '0;
            ld_rem_q  <= '0;
            ld_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ld_ptr_q  <= ld_ptr_d;
            ld_rem_q  <= ld_rem_d;
            ld_done_q <= ld_done_d;
        end
    end

    // No reset on the array itself: the clear sweep zeroes it.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_en        = reset && (state_q == StIdle);
    assign bus.busy     = !reset || (state_q != StIdle);
    assign bus.ld_ready = reset && (state_q == StLoad);
    assign bus.ld_done  = ld_done_q;
    assign bus.rd_ready = {NREAD{rd_en}};

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDRW-1:0] idx;
        assign idx = to_index(bus.rd_addr[i*BITWIDTH +: BITWIDTH]);

        imem_read_port #(
            .BITWIDTH (BITWIDTH)
        ) u_port (
            .clock      (clock),
            .reset      (reset),
            .accept     (bus.rd_valid[i] & rd_en),
            .addr_lo    (bus.rd_addr[i*BITWIDTH +: WORD_ALIGN_BITS]),
            .mem_word   (mem[idx]),
            .data       (bus.rd_data[i*BITWIDTH +: BITWIDTH]),
            .data_valid (bus.rd_data_valid[i]),
            .misalign   (bus.rd_misalign[i])
        );
    end

endmodule
